operand_addr_seq: RTL and testbench

Sequences PDP-11 operand addressing modes 0–7 against the 8×16 register file (two combinational read ports A/B, one write port addressed by selb, written on posedge clk). It computes one operand effective address per request, performs autoincrement, autodecrement and PC-advance writebacks, and issues the memory reads needed for index and deferred modes. It sits between the instruction decoder and the register file/memory bus, and is the only writer of the register file while busy.

---
 rtl/operand_addr_seq_if.sv | 34 +++
 rtl/operand_addr_seq.sv | 189 ++++++++++++++++++
 tb/tb_operand_addr_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/operand_addr_seq_if.sv
// Signal bundle between the operand address sequencer and its environment:
// decoder request/response, register file ports and the memory read port.
interface operand_addr_seq_if;
  logic        start;
  logic [2:0]  mode;
  logic [2:0]  rn;
  logic        byte_op;
  logic        busy;
  logic        done;
  logic [15:0] ea;
  logic        ea_is_reg;
  logic [2:0]  rf_sela;
  logic [2:0]  rf_selb;
  logic        rf_we;
  logic [15:0] rf_w;
  logic [15:0] rf_a;
  logic [15:0] rf_b;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport slave (
    input  start, mode, rn, byte_op, rf_a, rf_b, mem_ack, mem_rdata,
    output busy, done, ea, ea_is_reg, rf_sela, rf_selb, rf_we, rf_w,
           mem_req, mem_addr
  );

  modport master (
    output start, mode, rn, byte_op, rf_a, rf_b, mem_ack, mem_rdata,
    input  busy, done, ea, ea_is_reg, rf_sela, rf_selb, rf_we, rf_w,
           mem_req, mem_addr
  );
endinterface

// File: rtl/operand_addr_seq.sv
// PDP-11 operand addressing sequencer: computes one effective address per
// request, performs register writebacks and the index/deferred memory reads.
module operand_addr_seq (
  input logic             clk,
  input logic             reset,
  operand_addr_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WB, MEM1, MEM2, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  mode_reg, mode_next;
  logic [2:0]  rn_reg, rn_next;
  logic        byte_reg, byte_next;
  logic [15:0] val_reg, val_next;     // Rn value, or PC for modes 6/7
  logic [15:0] base_reg, base_next;   // index base for modes 6/7
  logic [15:0] addr_reg, addr_next;   // first memory read address
  logic [15:0] addr2_reg, addr2_next; // deferred address for mode 7
  logic [15:0] ea_reg, ea_next;
  logic        ea_is_reg_reg, ea_is_reg_next;
  logic        done_reg;
  logic [15:0] step;
  logic [15:0] wb_addr;

  // SP and PC always move by a word; so do deferred modes 3 and 5.
  always_comb begin
    step = (!byte_reg || rn_reg >= 3'd6 || mode_reg == 3'd3 || mode_reg == 3'd5)
           ? 16'd2 : 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      mode_reg      <= 3'd0;
      rn_reg        <= 3'd0;
      byte_reg      <= 1'b0;
      val_reg       <= 16'd0;
      base_reg      <= 16'd0;
      addr_reg      <= 16'd0;
      addr2_reg     <= 16'd0;
      ea_reg        <= 16'd0;
      ea_is_reg_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      rn_reg        <= rn_next;
      byte_reg      <= byte_next;
      val_reg       <= val_next;
      base_reg      <= base_next;
      addr_reg      <= addr_next;
      addr2_reg     <= addr2_next;
      ea_reg        <= ea_next;
      ea_is_reg_reg <= ea_is_reg_next;
      done_reg      <= (state_reg == DONE);
    end
  end

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    rn_next        = rn_reg;
    byte_next      = byte_reg;
    val_next       = val_reg;
    base_next      = base_reg;
    addr_next      = addr_reg;
    addr2_next     = addr2_reg;
    ea_next        = ea_reg;
    ea_is_reg_next = ea_is_reg_reg;
    wb_addr        = 16'd0;
    bus.rf_sela    = 3'd0;
    bus.rf_selb    = 3'd0;
    bus.rf_we      = 1'b0;
    bus.rf_w       = 16'd0;
    bus.mem_req    = 1'b0;
    bus.mem_addr   = 16'd0;

    unique case (state_reg)
      IDLE: begin
        // The done pulse cycle still counts as busy, so no accept there.
        if (bus.start && !done_reg) begin
          mode_next  = bus.mode;
          rn_next    = bus.rn;
          byte_next  = bus.byte_op;
          state_next = RD;
        end
      end

      RD: begin
        if (mode_reg >= 3'd6) begin
          bus.rf_sela = rn_reg;
          bus.rf_selb = 3'd7;
          base_next   = bus.rf_a;
          val_next    = bus.rf_b;
        end else begin
          bus.rf_selb = rn_reg;
          val_next    = bus.rf_b;
        end
        case (mode_reg)
          3'd0: begin
            ea_next        = {13'b0, rn_reg};
            ea_is_reg_next = 1'b1;
            state_next     = DONE;
          end
          3'd1: begin
            ea_next        = bus.rf_b;
            ea_is_reg_next = 1'b0;
            state_next     = DONE;
          end
          default: state_next = WB;
        endcase
      end

      WB: begin
        bus.rf_we = 1'b1;
        case (mode_reg)
          3'd2, 3'd3: begin
            bus.rf_selb = rn_reg;
            bus.rf_w    = val_reg + step;
            wb_addr     = val_reg;
          end
          3'd4, 3'd5: begin
            bus.rf_selb = rn_reg;
            bus.rf_w    = val_reg - step;
            wb_addr     = val_reg - step;
          end
          default: begin
            bus.rf_selb = 3'd7;
            bus.rf_w    = val_reg + 16'd2;
            wb_addr     = val_reg;
            // Index relative to PC uses the PC after the index word.
            if (rn_reg == 3'd7)
              base_next = val_reg + 16'd2;
          end
        endcase
        addr_next = wb_addr;
        if (mode_reg == 3'd2 || mode_reg == 3'd4) begin
          ea_next        = wb_addr;
          ea_is_reg_next = 1'b0;
          state_next     = DONE;
        end else begin
          state_next = MEM1;
        end
      end

      MEM1: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_reg;
        if (bus.mem_ack) begin
          ea_is_reg_next = 1'b0;
          case (mode_reg)
            3'd6: begin
              ea_next    = base_reg + bus.mem_rdata;
              state_next = DONE;
            end
            3'd7: begin
              addr2_next = base_reg + bus.mem_rdata;
              state_next = MEM2;
            end
            default: begin
              ea_next    = bus.mem_rdata;
              state_next = DONE;
            end
          endcase
        end
      end

      MEM2: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr2_reg;
        if (bus.mem_ack) begin
          ea_next        = bus.mem_rdata;
          ea_is_reg_next = 1'b0;
          state_next     = DONE;
        end
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign bus.busy      = (state_reg != IDLE) || done_reg;
  assign bus.done      = done_reg;
  assign bus.ea        = ea_reg;
  assign bus.ea_is_reg = ea_is_reg_reg;

endmodule

// File: tb/tb_operand_addr_seq.sv
// Bench for operand_addr_seq: register file and memory models around the DUT,
// directed cases followed by random requests checked against an address model.
module tb_operand_addr_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;

  operand_addr_seq_if bus ();

  operand_addr_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  logic [15:0] rf [0:7];
  logic [15:0] exp_rf [0:7];
  logic [15:0] mem_log [0:1023];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_idx = 3'd0;
  logic [15:0] pl_val = 16'd0;
  int we_count = 0;
  int mem_n = 0;
  int w1_cfg = 0;
  int w2_cfg = 0;
  int waited = 0;
  int ridx = 0;
  int errors = 0;
  int checks = 0;

  assign bus.rf_a = rf[bus.rf_sela];
  assign bus.rf_b = rf[bus.rf_selb];

  // Register file: DUT write port, plus a preload path used only while idle.
  always @(posedge clk) begin
    if (bus.rf_we) begin
      rf[bus.rf_selb] <= bus.rf_w;
      we_count <= we_count + 1;
    end else if (pl_en) begin
      rf[pl_idx] <= pl_val;
    end
  end

  // Memory responder: acknowledges after the configured number of wait cycles.
  always @(negedge clk) begin
    if (reset || !bus.busy) begin
      bus.mem_ack = 1'b0;
      waited = 0;
      ridx = 0;
    end else begin
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        waited = 0;
        ridx++;
      end
      if (bus.mem_req) begin
        if (waited >= ((ridx == 0) ? w1_cfg : w2_cfg)) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr];
          if (mem_n < 1024) mem_log[mem_n] = bus.mem_addr;
          mem_n++;
        end else begin
          waited++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_reg(input int i, input logic [15:0] v);
    @(negedge clk);
    pl_en = 1'b1;
    pl_idx = 3'(i);
    pl_val = v;
    exp_rf[i] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Expected outcome of one request, straight from the addressing-mode rules.
  task automatic model(input logic [2:0] m, input logic [2:0] r, input logic b,
                       input int w1, input int w2,
                       output logic [15:0] ea, output logic isreg, output int lat,
                       output int nwe, output int nmem,
                       output logic [15:0] a1, output logic [15:0] a2);
    logic [15:0] step, rv, pc, base, x;
    step = (!b || r >= 3'd6 || m == 3'd3 || m == 3'd5) ? 16'd2 : 16'd1;
    rv = exp_rf[r];
    pc = exp_rf[7];
    isreg = 1'b0; nwe = 1; nmem = 0; a1 = 16'd0; a2 = 16'd0; ea = 16'd0; lat = 0;
    case (m)
      3'd0: begin ea = {13'b0, r}; isreg = 1'b1; nwe = 0; lat = 2; end
      3'd1: begin ea = rv; nwe = 0; lat = 2; end
      3'd2: begin ea = rv; exp_rf[r] = rv + step; lat = 3; end
      3'd4: begin ea = rv - step; exp_rf[r] = rv - step; lat = 3; end
      3'd3, 3'd5: begin
        a1 = (m == 3'd3) ? rv : rv - step;
        exp_rf[r] = (m == 3'd3) ? rv + step : rv - step;
        ea = mem[a1]; nmem = 1; lat = 4 + w1;
      end
      default: begin
        a1 = pc;
        exp_rf[7] = pc + 16'd2;
        base = (r == 3'd7) ? pc + 16'd2 : rv;
        x = mem[pc];
        nmem = 1;
        if (m == 3'd6) begin
          ea = base + x; lat = 4 + w1;
        end else begin
          a2 = base + x; ea = mem[a2]; nmem = 2; lat = 5 + w1 + w2;
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [2:0] m, input logic [2:0] r, input logic b,
                        input int w1, input int w2, input bit glitch);
    logic [15:0] e_ea, a1, a2;
    logic e_isreg;
    int lat, nwe, nmem, we0, mn0, n;
    string t;
    model(m, r, b, w1, w2, e_ea, e_isreg, lat, nwe, nmem, a1, a2);
    t = $sformatf("m%0d r%0d b%0d", m, r, b);
    @(negedge clk);
    w1_cfg = w1; w2_cfg = w2;
    bus.mode = m; bus.rn = r; bus.byte_op = b; bus.start = 1'b1;
    we0 = we_count; mn0 = mem_n;
    @(negedge clk);
    bus.start = glitch;
    if (glitch) bus.mode = m ^ 3'd1;
    chk({t, " busy"}, 16'(bus.busy), 16'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end
    chk({t, " latency"}, 16'(n), 16'(lat));
    chk({t, " ea"}, bus.ea, e_ea);
    chk({t, " ea_is_reg"}, 16'(bus.ea_is_reg), 16'(e_isreg));
    chk({t, " rf_we count"}, 16'(we_count - we0), 16'(nwe));
    chk({t, " mem reads"}, 16'(mem_n - mn0), 16'(nmem));
    if (nmem >= 1 && mn0 < 1024) chk({t, " mem_addr1"}, mem_log[mn0], a1);
    if (nmem == 2 && mn0 + 1 < 1024) chk({t, " mem_addr2"}, mem_log[mn0 + 1], a2);
    $display("op %s w=%0d/%0d ea=%h is_reg=%0d cycles=%0d", t, w1, w2, bus.ea, bus.ea_is_reg, n);
    @(negedge clk);
    chk({t, " done drop"}, 16'(bus.done), 16'd0);
    chk({t, " busy drop"}, 16'(bus.busy), 16'd0);
    if (glitch) begin
      @(negedge clk);
      chk({t, " ignored start"}, 16'(bus.busy), 16'd0);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("%s R%0d", t, i), rf[i], exp_rf[i]);
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.mode = 3'd0; bus.rn = 3'd0; bus.byte_op = 1'b0;
    bus.mem_rdata = 16'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    #12;
    chk("reset busy", 16'(bus.busy), 16'd0);
    chk("reset done", 16'(bus.done), 16'd0);
    chk("reset ea", bus.ea, 16'd0);
    chk("reset mem_req", 16'(bus.mem_req), 16'd0);
    chk("reset rf_we", 16'(bus.rf_we), 16'd0);
    for (int i = 0; i < 8; i++) set_reg(i, 16'($urandom));
    @(negedge clk);
    reset = 1'b0;

    set_reg(3, 16'h1000);
    run_op(3'd2, 3'd3, 1'b1, 0, 0, 1'b0);
    set_reg(6, 16'h0000);
    run_op(3'd4, 3'd6, 1'b1, 0, 0, 1'b0);
    set_reg(7, 16'h0200);
    mem[16'h0200] = 16'h0010;
    run_op(3'd6, 3'd7, 1'b0, 2, 0, 1'b0);
    set_reg(2, 16'h3000);
    set_reg(7, 16'h0100);
    mem[16'h0100] = 16'h0004;
    mem[16'h3004] = 16'h5555;
    run_op(3'd7, 3'd2, 1'b0, 1, 2, 1'b0);
    run_op(3'd0, 3'd5, 1'b0, 0, 0, 1'b1);

    // Reset while waiting in MEM1: the earlier autoincrement must survive.
    set_reg(1, 16'h4000);
    @(negedge clk);
    w1_cfg = 6;
    bus.mode = 3'd3; bus.rn = 3'd1; bus.byte_op = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst reached MEM1", 16'(bus.mem_req), 16'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst busy", 16'(bus.busy), 16'd0);
    chk("rst done", 16'(bus.done), 16'd0);
    chk("rst ea", bus.ea, 16'd0);
    chk("rst ea_is_reg", 16'(bus.ea_is_reg), 16'd0);
    chk("rst mem_req", 16'(bus.mem_req), 16'd0);
    chk("rst mem_addr", bus.mem_addr, 16'd0);
    chk("rst rf_we", 16'(bus.rf_we), 16'd0);
    chk("rst rf_sela", 16'(bus.rf_sela), 16'd0);
    chk("rst rf_selb", 16'(bus.rf_selb), 16'd0);
    chk("rst rf_w", bus.rf_w, 16'd0);
    exp_rf[1] = 16'h4002;
    chk("rst R1 kept", rf[1], exp_rf[1]);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd1, 3'd1, 1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
